// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: queues read/write commands, issues one bus access at a
// time, and returns read data / error status on a valid/ready response port.
module reg_bus_initiator #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bus_sel,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t              fifo_q [FIFO_DEPTH];
  cmd_t              fifo_d [FIFO_DEPTH];
  logic [PTR_W:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  state_t            state_q, state_d;
  cmd_t              bus_q, bus_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic full, empty, push, head_legal;
  cmd_t head;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign push       = cmd_valid & ~full;
  assign head       = fifo_q[rptr_q[PTR_W-1:0]];
  assign head_legal = ({1'b0, head.addr} < (ADDR_W+1)'(NUM_REGS));

  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    if (push) begin
      fifo_d[wptr_q[PTR_W-1:0]] = {cmd_write, cmd_addr, cmd_wdata};
      wptr_d                    = wptr_q + (PTR_W+1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    bus_d   = bus_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          rptr_d = rptr_q + (PTR_W+1)'(1);
          if (head_legal) begin
            bus_d   = head;
            timer_d = '0;
            state_d = ACCESS;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        timer_d = timer_q + TMR_W'(1);
        // An ack on the last timer cycle still counts as a normal completion.
        if (bus_ack) begin
          rdata_d = bus_q.wr ? '0 : bus_rdata;
          err_d   = 1'b0;
          bus_d   = '0;
          state_d = RESP;
        end else if (timer_q == TMR_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          bus_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      bus_q   <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      bus_q   <= bus_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Entry storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign cmd_ready = ~full;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign bus_sel   = (state_q == ACCESS);
  assign bus_wr    = bus_q.wr;
  assign bus_addr  = bus_q.addr;
  assign bus_wdata = bus_q.wdata;
  assign busy      = ~empty | (state_q != IDLE);

endmodule
